seg7_mux_driver: RTL and testbench

Time-multiplexed driver for a bank of `DIGITS` common-select seven-segment displays. It holds a frame-synchronous shadow copy of a hex value, scans digits at a programmable rate, and inserts anti-ghosting blank gaps between digits. It also supports optional leading-zero suppression and a per-digit decimal point. It sits between the datapath, which presents a packed nibble vector and a `load` strobe, and the board display pins.

---
 rtl/seg7_mux_driver.sv | 171 +++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed seven-segment driver with a frame-synchronous shadow value,
// anti-ghosting blank gaps, leading-zero suppression and per-digit decimal points.
module seg7_mux_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  en,
  input  logic                  lz_suppress,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CntMax   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BlankLim = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IdxMax   = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shown_val_q, shown_val_d;
  logic [DIGITS-1:0]   shown_dp_q, shown_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                cnt_wrap;
  logic                apply;
  logic                blank;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   supp;
  logic                zero_above;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h5F;
      4'h1:    s = 7'h03;
      4'h2:    s = 7'h76;
      4'h3:    s = 7'h73;
      4'h4:    s = 7'h2B;
      4'h5:    s = 7'h79;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h43;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h6F;
      4'hB:    s = 7'h3D;
      4'hC:    s = 7'h5C;
      4'hD:    s = 7'h37;
      4'hE:    s = 7'h7C;
      default: s = 7'h6C;
    endcase
    return s;
  endfunction

  assign cnt_wrap = (cnt_q == CntMax);
  // Shadow copy is refreshed on the frame boundary, or freely while scanning is off.
  assign apply    = !en || (cnt_wrap && (idx_q == IdxMax));

  // Prescaler and digit index advance.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pending/shown double buffer; a load on the apply edge bypasses the pending stage.
  always_comb begin
    shown_val_d = shown_val_q;
    shown_dp_d  = shown_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pending_d   = pending_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
    if (apply) begin
      if (load) begin
        shown_val_d = value;
        shown_dp_d  = dp_in;
      end else if (pending_q) begin
        shown_val_d = pend_val_q;
        shown_dp_d  = pend_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Leading-zero map: a digit is blanked when it and every higher digit are zero.
  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (shown_val_q[4*k +: 4] == 4'h0);
      supp[k]    = lz_suppress && zero_above && (k != 0);
    end
  end

  assign blank = (cnt_q < BlankLim);
  assign nib   = shown_val_q[{idx_q, 2'b00} +: 4];

  // Next display outputs for the currently selected slot.
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    if (en && !blank) begin
      an_d = DIGITS'(1) << idx_q;
      dp_d = shown_dp_q[idx_q];
      if (!supp[idx_q]) begin
        seg_d = hex7(nib);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shown_val_q <= '0;
      shown_dp_q  <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      an_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shown_val_q <= shown_val_d;
      shown_dp_q  <= shown_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver with DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_mux_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        en;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;

  int n_cmp;
  int n_err;
  int k;        // cycles since scanning was enabled
  logic [3:0] exp_dp;

  logic [6:0] tbl [16] = '{7'h5F, 7'h03, 7'h76, 7'h73, 7'h2B, 7'h79, 7'h7D, 7'h43,
                           7'h7F, 7'h7B, 7'h6F, 7'h3D, 7'h5C, 7'h37, 7'h7C, 7'h6C};

  seg7_mux_driver #(
    .DIGITS      (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .en         (en),
    .lz_suppress(lz_suppress),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // One cycle with scan expectations: output at step k reflects state k-1.
  task automatic step_chk(input logic [6:0] s);
    int cm;
    int im;
    logic lit;
    tick();
    cm  = (k - 1) % 8;
    im  = ((k - 1) / 8) % 4;
    lit = (cm >= 2);
    check("an",  32'(an),  lit ? 32'(4'b0001 << im) : 32'h0);
    check("seg", 32'(seg), lit ? 32'(s) : 32'h0);
    check("dp",  32'(dp),  lit ? 32'(exp_dp[im]) : 32'h0);
  endtask

  task automatic check_slot(input logic [6:0] s);
    for (int i = 0; i < 8; i++) step_chk(s);
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    check_slot(s0);
    check_slot(s1);
    check_slot(s2);
    check_slot(s3);
  endtask

  task automatic enable();
    en = 1'b1;
    k  = 0;
  endtask

  task automatic disable_scan();
    en = 1'b0;
    tick();
  endtask

  // Only meaningful while en=0, where a load lands in the shown register at once.
  task automatic load_direct(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 1; value = '0; dp_in = '0; load = 0; en = 0; lz_suppress = 0;
    n_cmp = 0; n_err = 0; k = 0; exp_dp = '0;

    #12;
    check("rst_an", 32'(an), 0);
    check("rst_seg", 32'(seg), 0);
    check("rst_dp", 32'(dp), 0);
    check("rst_pending", 32'(pending), 0);
    @(negedge clk);
    rst = 0;

    // Scan of 0x1234, decimal point on digit 2.
    load_direct(16'h1234, 4'b0100);
    exp_dp = 4'b0100;
    enable();
    check_frame(7'h2B, 7'h73, 7'h76, 7'h03);
    check_frame(7'h2B, 7'h73, 7'h76, 7'h03);

    // Tearing: load 0xABCD during slot 2.
    check_slot(7'h2B);
    check_slot(7'h73);
    value = 16'hABCD; dp_in = 4'b1000; load = 1;
    step_chk(7'h76);
    load = 0;
    check("tear_pend_rise", 32'(pending), 1);
    for (int i = 0; i < 7; i++) step_chk(7'h76);
    check_slot(7'h03);
    check("tear_pend_clr", 32'(pending), 0);
    exp_dp = 4'b1000;
    check_frame(7'h37, 7'h5C, 7'h3D, 7'h6F);

    // Boundary race: load on the frame-boundary edge.
    check_slot(7'h37);
    check_slot(7'h5C);
    check_slot(7'h3D);
    for (int i = 0; i < 7; i++) step_chk(7'h6F);
    value = 16'h5555; dp_in = 4'b0000; load = 1;
    step_chk(7'h6F);
    load = 0;
    check("race_pend", 32'(pending), 0);
    exp_dp = 4'b0000;
    check_frame(7'h79, 7'h79, 7'h79, 7'h79);
    check("race_pend_end", 32'(pending), 0);

    // Double load within one frame: only the latest survives.
    value = 16'h1111; load = 1;
    step_chk(7'h79);
    load = 0;
    check("dbl_pend1", 32'(pending), 1);
    for (int i = 0; i < 7; i++) step_chk(7'h79);
    value = 16'h2222; load = 1;
    step_chk(7'h79);
    load = 0;
    for (int i = 0; i < 7; i++) step_chk(7'h79);
    check_slot(7'h79);
    check_slot(7'h79);
    check("dbl_pend_clr", 32'(pending), 0);
    check_frame(7'h76, 7'h76, 7'h76, 7'h76);

    // Decode sweep on digit 0.
    disable_scan();
    for (int n = 0; n < 16; n++) begin
      load_direct(16'(n), 4'b0000);
      enable();
      tick(); tick(); tick();
      check("sweep_an", 32'(an), 1);
      check($sformatf("sweep_seg_%0h", n), 32'(seg), 32'(tbl[n]));
      disable_scan();
    end

    // Leading-zero suppression.
    lz_suppress = 1;
    load_direct(16'h0070, 4'b0000);
    enable();
    check_frame(7'h5F, 7'h43, 7'h00, 7'h00);
    disable_scan();
    load_direct(16'h0000, 4'b0000);
    enable();
    check_frame(7'h5F, 7'h00, 7'h00, 7'h00);
    disable_scan();
    lz_suppress = 0;

    // Asynchronous reset mid-slot with a pending value.
    load_direct(16'h1234, 4'b0000);
    enable();
    for (int i = 0; i < 5; i++) tick();
    value = 16'h9999; load = 1;
    tick();
    load = 0;
    check("pre_rst_pend", 32'(pending), 1);
    check("pre_rst_an", 32'(an), 1);
    #2;
    rst = 1;
    #1;
    check("async_rst_an", 32'(an), 0);
    check("async_rst_seg", 32'(seg), 0);
    check("async_rst_dp", 32'(dp), 0);
    check("async_rst_pend", 32'(pending), 0);
    @(negedge clk);
    rst = 0;
    k = 0;
    check_slot(7'h5F);

    // Disable for 20 cycles, then restart at digit 0.
    en = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("dis_an", 32'(an), 0);
      check("dis_seg", 32'(seg), 0);
    end
    load_direct(16'h1234, 4'b0000);
    enable();
    check_slot(7'h2B);
    check_slot(7'h73);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
